// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a request/ack instruction memory and fills the IF/ID register.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_REQ  | request to pc_q outstanding; ack loads IF/ID (or skid if stalled)
// ST_HOLD | response parked in skid buffer while decode is stalled; no request
// ST_KILL | response to kill_addr still owed by memory; it will be dropped
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    fetch_stage_if.master     imem,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc_plus4
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state, state_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] kill_addr, kill_addr_nx;
    logic [31:0] skid_pc, skid_pc_nx;
    logic [31:0] skid_instr, skid_instr_nx;
    logic        valid_q, valid_nx;
    logic [31:0] ifpc_q, ifpc_nx;
    logic [31:0] ifinstr_q, ifinstr_nx;

    logic [31:0] redirect_target;
    logic [31:0] pc_inc;

    // Clearing the low bits with a mask keeps every redirect_pc bit in use.
    assign redirect_target = redirect_pc & ~32'h3;
    assign pc_inc          = pc_q + 32'd4;

    // Request is gated by rst_n so it drops the moment reset asserts, abandoning any pending fetch.
    assign imem.imem_req  = rst_n && (state != ST_HOLD);
    assign imem.imem_addr = (state == ST_KILL) ? kill_addr : pc_q;

    assign if_valid    = valid_q;
    assign if_pc       = ifpc_q;
    assign if_instr    = ifinstr_q;
    assign if_pc_plus4 = ifpc_q + 32'd4;

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            pc_q       <= RESET_PC_ALIGNED;
            kill_addr  <= 32'h0;
            skid_pc    <= 32'h0;
            skid_instr <= NOP_INSTR;
            valid_q    <= 1'b0;
            ifpc_q     <= 32'h0;
            ifinstr_q  <= NOP_INSTR;
        end else begin
            state      <= state_nx;
            pc_q       <= pc_nx;
            kill_addr  <= kill_addr_nx;
            skid_pc    <= skid_pc_nx;
            skid_instr <= skid_instr_nx;
            valid_q    <= valid_nx;
            ifpc_q     <= ifpc_nx;
            ifinstr_q  <= ifinstr_nx;
        end
    end

    // Next-state and next-datapath logic; redirect outranks stall and ack.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc_q;
        kill_addr_nx  = kill_addr;
        skid_pc_nx    = skid_pc;
        skid_instr_nx = skid_instr;
        valid_nx      = valid_q;
        ifpc_nx       = ifpc_q;
        ifinstr_nx    = ifinstr_q;

        if (redirect_valid) begin
            valid_nx      = 1'b0;
            ifinstr_nx    = NOP_INSTR;
            skid_pc_nx    = 32'h0;
            skid_instr_nx = NOP_INSTR;
            pc_nx         = redirect_target;
            case (state)
                ST_REQ: begin
                    if (!imem.imem_ack) begin
                        state_nx     = ST_KILL;
                        kill_addr_nx = pc_q;
                    end else begin
                        state_nx = ST_REQ;
                    end
                end
                // An ack arriving alongside the redirect settles the old request.
                ST_KILL: state_nx = imem.imem_ack ? ST_REQ : ST_KILL;
                default: state_nx = ST_REQ;
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        pc_nx = pc_inc;
                        if (stall) begin
                            skid_pc_nx    = pc_q;
                            skid_instr_nx = imem.imem_rdata;
                            state_nx      = ST_HOLD;
                        end else begin
                            valid_nx   = 1'b1;
                            ifpc_nx    = pc_q;
                            ifinstr_nx = imem.imem_rdata;
                        end
                    end else if (!stall) begin
                        valid_nx   = 1'b0;
                        ifinstr_nx = NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        valid_nx   = 1'b1;
                        ifpc_nx    = skid_pc;
                        ifinstr_nx = skid_instr;
                        state_nx   = ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (!stall) begin
                        valid_nx   = 1'b0;
                        ifinstr_nx = NOP_INSTR;
                    end
                    if (imem.imem_ack) begin
                        state_nx = ST_REQ;
                    end
                end
                default: state_nx = ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus a scoreboard of expected IF/ID instructions.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, if_pc_plus4;
    logic        held = 1'b0;

    fetch_stage_if mem();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mem),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    // Memory model: data is a fixed function of the address.
    assign mem.imem_rdata = mem.imem_addr ^ KEY;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        push;
        logic [31:0] ppc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[34];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tv(input int i, input logic a, input logic s, input logic r, input logic [31:0] rp,
                      input logic p, input logic [31:0] pp, input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ep);
        tbl[i] = '{ack: a, stall: s, redir: r, rpc: rp, push: p, ppc: pp,
                   e_req: er, e_addr: ea, e_valid: ev, e_pc: ep};
    endtask

    // An edge taken under stall (without redirect) leaves IF/ID unchanged.
    always @(posedge clk) held <= stall & ~redirect_valid;

    // Every newly loaded valid IF/ID entry must be the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && if_valid && !held) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got pc=%h instr=%h exp none", if_pc, if_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    bad++;
                    $display("FAIL sb_order got pc=%h instr=%h exp pc=%h instr=%h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //  i  ack st rd rpc            push ppc           req addr          vld pc
        tv( 0, 1, 0, 0, 32'h0,          1, 32'h0,         1, 32'h0,         0, 32'h0);
        tv( 1, 1, 0, 0, 32'h0,          1, 32'h4,         1, 32'h4,         1, 32'h0);
        tv( 2, 1, 0, 0, 32'h0,          1, 32'h8,         1, 32'h8,         1, 32'h4);
        tv( 3, 1, 0, 0, 32'h0,          1, 32'hC,         1, 32'hC,         1, 32'h8);
        tv( 4, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h10,        1, 32'hC);
        tv( 5, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h10,        0, 32'h0);
        tv( 6, 1, 0, 0, 32'h0,          1, 32'h10,        1, 32'h10,        0, 32'h0);
        tv( 7, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h14,        1, 32'h10);
        tv( 8, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h14,        0, 32'h0);
        tv( 9, 1, 0, 0, 32'h0,          1, 32'h14,        1, 32'h14,        0, 32'h0);
        tv(10, 1, 0, 0, 32'h0,          1, 32'h18,        1, 32'h18,        1, 32'h14);
        tv(11, 1, 1, 0, 32'h0,          0, 32'h0,         1, 32'h1C,        1, 32'h18);
        tv(12, 0, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         1, 32'h18);
        tv(13, 0, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         1, 32'h18);
        tv(14, 0, 0, 0, 32'h0,          1, 32'h1C,        0, 32'h0,         1, 32'h18);
        tv(15, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h20,        1, 32'h1C);
        tv(16, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h20,        0, 32'h0);
        tv(17, 0, 0, 1, 32'h103,        0, 32'h0,         1, 32'h20,        0, 32'h0);
        tv(18, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h20,        0, 32'h0);
        tv(19, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h20,        0, 32'h0);
        tv(20, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h100,       0, 32'h0);
        tv(21, 1, 0, 0, 32'h0,          1, 32'h100,       1, 32'h100,       0, 32'h0);
        tv(22, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h104,       1, 32'h100);
        tv(23, 1, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,         1, 32'h104,       0, 32'h0);
        tv(24, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
        tv(25, 1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0);
        tv(26, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC);
        tv(27, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0,         0, 32'h0);
        tv(28, 0, 0, 1, 32'h40,         0, 32'h0,         1, 32'h0,         0, 32'h0);
        tv(29, 0, 0, 1, 32'h82,         0, 32'h0,         1, 32'h0,         0, 32'h0);
        tv(30, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0,         0, 32'h0);
        tv(31, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h80,        0, 32'h0);
        tv(32, 1, 0, 0, 32'h0,          1, 32'h80,        1, 32'h80,        0, 32'h0);
        tv(33, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h84,        1, 32'h80);

        mem.imem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",    {31'h0, mem.imem_req}, 32'h0);
        chk("rst_valid",  {31'h0, if_valid},     32'h0);
        chk("rst_pc",     if_pc,                 32'h0);
        chk("rst_instr",  if_instr,              NOP);
        chk("rst_pc4",    if_pc_plus4,           32'h4);
        chk("rst_addr",   mem.imem_addr,         32'h0);

        for (int i = 0; i < 34; i++) begin
            @(posedge clk);
            #1;
            rst_n          = 1'b1;
            mem.imem_ack   = tbl[i].ack;
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            if (tbl[i].push) sb.push_back('{pc: tbl[i].ppc, instr: tbl[i].ppc ^ KEY});
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'h0, mem.imem_req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), mem.imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("v%0d_pc4", i), if_pc_plus4, tbl[i].e_pc + 32'd4);
            end else begin
                chk($sformatf("v%0d_nop", i), if_instr, NOP);
            end
        end

        // Wrapped fetch: PC 0xFFFF_FFFC must report pc+4 as zero.
        chk("wrap_pc4_zero", tbl[26].e_pc + 32'd4, 32'h0);

        // Reset dropped mid-cycle while the request to 0x84 is pending.
        #2;
        rst_n = 1'b0;
        mem.imem_ack = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, mem.imem_req}, 32'h0);
        chk("mid_rst_valid", {31'h0, if_valid},     32'h0);
        chk("mid_rst_pc",    if_pc,                 32'h0);
        chk("mid_rst_instr", if_instr,              NOP);
        chk("mid_rst_pc4",   if_pc_plus4,           32'h4);
        chk("mid_rst_addr",  mem.imem_addr,         32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req",  {31'h0, mem.imem_req}, 32'h1);
        chk("restart_addr", mem.imem_addr,         32'h0);
        @(posedge clk);
        #1;
        mem.imem_ack = 1'b1;
        sb.push_back('{pc: 32'h0, instr: 32'h0 ^ KEY});
        @(posedge clk);
        #1;
        mem.imem_ack = 1'b0;
        @(negedge clk);
        chk("restart_valid", {31'h0, if_valid}, 32'h1);
        chk("restart_pc",    if_pc,             32'h0);
        chk("restart_next",  mem.imem_addr,     32'h4);
        @(negedge clk);

        chk("sb_drained", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
